// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM framing constants and state encoding
package tdm_pkg;

  localparam int NCH    = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - 2-bit slot counter with clear, load-to-1 and wrapping increment
import tdm_pkg::*;

module tdm_slot_ctr (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load1,
  input  logic              inc,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  // Next slot: clear wins over load, load wins over increment; wraps naturally at 2 bits
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SLOT_W'(1);
    end else if (inc) begin
      slot_d = slot_q + SLOT_W'(1);
    end
  end

  // Slot register, synchronous reset to slot 0
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SLOT_W'(NCH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with frame lock and misalignment detection
import tdm_pkg::*;

module tdm_demux4 #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               frame_start,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]     out_valid,
  output logic               frame_done,
  output logic               locked,
  output logic               sync_err
);

  tdm_state_e          state_q, state_d;
  logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
  logic [NCH-1:0]      out_valid_q, out_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                locked_q, locked_d;
  logic                sync_err_q, sync_err_d;

  logic [SLOT_W-1:0]   slot;
  logic                slot_last;
  logic                ctr_clr, ctr_load1, ctr_inc;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (ctr_clr),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .slot  (slot),
    .last  (slot_last)
  );

  // Frame tracking and write steering; frame_start always realigns to slot 0
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = '0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    ctr_clr      = 1'b0;
    ctr_load1    = 1'b0;
    ctr_inc      = 1'b0;
    if (in_valid) begin
      if (state_q == ST_HUNT) begin
        if (frame_start) begin
          out_data_d[0 +: WIDTH] = in_data;
          out_valid_d[0]         = 1'b1;
          ctr_load1              = 1'b1;
          state_d                = ST_RUN;
        end
      end else if (frame_start) begin
        sync_err_d             = (slot != '0);
        out_data_d[0 +: WIDTH] = in_data;
        out_valid_d[0]         = 1'b1;
        ctr_load1              = 1'b1;
      end else if (slot == '0) begin
        sync_err_d = 1'b1;
        ctr_clr    = 1'b1;
        state_d    = ST_HUNT;
      end else begin
        out_data_d[int'(slot)*WIDTH +: WIDTH] = in_data;
        out_valid_d[slot]                     = 1'b1;
        frame_done_d                          = slot_last;
        ctr_inc                               = 1'b1;
      end
    end
    locked_d = (state_d == ST_RUN);
  end

  // Registered state and outputs, reset clears held channel data
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4 against a frame-level model
module tb_tdm_demux4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        frame_start = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        frame_done;
  logic        locked;
  logic        sync_err;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: channel contents, whether a frame is being followed, next expected slot
  logic [7:0] m_ch [4];
  bit         m_run = 1'b0;
  int         m_slot = 0;
  logic [3:0] e_valid = 4'h0;
  bit         e_fd = 1'b0;
  bit         e_se = 1'b0;

  tdm_demux4 #(.WIDTH(8), .NCH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .frame_done  (frame_done),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each accepted edge
  always @(posedge clk) begin
    e_valid = 4'h0;
    e_fd    = 1'b0;
    e_se    = 1'b0;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
      m_run  = 1'b0;
      m_slot = 0;
    end else if (in_valid) begin
      if (!m_run) begin
        if (frame_start) begin
          m_ch[0] = in_data; e_valid = 4'b0001; m_slot = 1; m_run = 1'b1;
        end
      end else if (frame_start) begin
        e_se = (m_slot != 0);
        m_ch[0] = in_data; e_valid = 4'b0001; m_slot = 1;
      end else if (m_slot == 0) begin
        e_se = 1'b1; m_run = 1'b0;
      end else begin
        m_ch[m_slot] = in_data;
        e_valid = 4'(1 << m_slot);
        e_fd = (m_slot == 3);
        m_slot = (m_slot + 1) % 4;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_data",   out_data, {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
      check("out_valid",  {28'h0, out_valid}, {28'h0, e_valid});
      check("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
      check("locked",     {31'h0, locked}, {31'h0, m_run});
      check("sync_err",   {31'h0, sync_err}, {31'h0, e_se});
      check("onehot",     $countones(out_valid) <= 1, 32'd1);
    end
  end

  task automatic drive(input bit v, input bit fs, input logic [7:0] d);
    in_valid = v; frame_start = fs; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; frame_start = 1'b0; in_data = 8'h00;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset then lock
    do_reset(2);
    chk_en = 1'b1;
    check("rst_data", out_data, 32'h0);
    check("rst_locked", {31'h0, locked}, 32'h0);
    drive(1, 1, 8'hA1);
    check("t1_v0", {28'h0, out_valid}, 32'h1);
    check("t1_lock", {31'h0, locked}, 32'h1);
    drive(1, 0, 8'hB2);
    check("t1_v1", {28'h0, out_valid}, 32'h2);
    drive(1, 0, 8'hC3);
    check("t1_v2", {28'h0, out_valid}, 32'h4);
    drive(1, 0, 8'hD4);
    check("t1_v3", {28'h0, out_valid}, 32'h8);
    check("t1_fd", {31'h0, frame_done}, 32'h1);
    check("t1_data", out_data, 32'hD4C3B2A1);

    // 2: hunt drop
    do_reset(1);
    drive(1, 0, 8'h55);
    drive(1, 0, 8'h66);
    check("t2_data", out_data, 32'h0);
    check("t2_lock", {31'h0, locked}, 32'h0);
    drive(1, 1, 8'h77);
    check("t2_ch0", out_data, 32'h00000077);
    check("t2_lock1", {31'h0, locked}, 32'h1);

    // 3: gaps inside a frame
    do_reset(1);
    drive(1, 1, 8'h11); repeat (3) drive(0, 0, 8'hEE);
    drive(1, 0, 8'h22); repeat (3) drive(0, 0, 8'hEE);
    drive(1, 0, 8'h33); repeat (3) drive(0, 0, 8'hEE);
    drive(1, 0, 8'h44);
    check("t3_fd", {31'h0, frame_done}, 32'h1);
    drive(0, 0, 8'h00);
    check("t3_data", out_data, 32'h44332211);
    check("t3_idle_v", {28'h0, out_valid}, 32'h0);

    // 4: early frame start
    do_reset(1);
    drive(1, 1, 8'h10);
    drive(1, 0, 8'h20);
    drive(1, 1, 8'h99);
    check("t4_se", {31'h0, sync_err}, 32'h1);
    check("t4_data", out_data, 32'h00002099);
    check("t4_fd", {31'h0, frame_done}, 32'h0);
    drive(1, 0, 8'h30);
    check("t4_se_clr", {31'h0, sync_err}, 32'h0);
    check("t4_ch1", out_data, 32'h00003099);

    // 5: missing frame start
    do_reset(1);
    drive(1, 1, 8'h01); drive(1, 0, 8'h02); drive(1, 0, 8'h03); drive(1, 0, 8'h04);
    drive(1, 0, 8'h05);
    check("t5_se", {31'h0, sync_err}, 32'h1);
    check("t5_lock", {31'h0, locked}, 32'h0);
    check("t5_data", out_data, 32'h04030201);
    check("t5_v", {28'h0, out_valid}, 32'h0);
    drive(1, 0, 8'h06);
    check("t5_hunt_se", {31'h0, sync_err}, 32'h0);

    // 6: reset mid-frame
    do_reset(1);
    drive(1, 1, 8'h0A);
    drive(1, 0, 8'h0B);
    do_reset(1);
    check("t6_data", out_data, 32'h0);
    check("t6_lock", {31'h0, locked}, 32'h0);
    drive(1, 0, 8'h0C);
    check("t6_drop", out_data, 32'h0);
    check("t6_v", {28'h0, out_valid}, 32'h0);
    drive(1, 1, 8'h0D);
    drive(1, 0, 8'h0E);
    check("t6_relock", out_data, 32'h00000E0D);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
